// File: rtl/pmem_arbiter.sv
// N-port line arbiter in front of the single cacheline adaptor.
// One memory transaction outstanding; grant, address, write data and read data are registered.
//   state | meaning
//   IDLE  | no transaction outstanding, pending requests are arbitrated
//   BUSY  | pmem_read/pmem_write driven, waiting for pmem_resp
//   RESP  | req_resp pulse to the granted client
module pmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        ptr, ptr_next, grant, win, cand;
  logic                 found, load, done;
  logic [NUM_PORTS-1:0] pending;

  assign pending  = req_read | req_write;
  assign ptr_next = (grant == IW'(NUM_PORTS - 1)) ? '0 : grant + IW'(1);

  // Round-robin search starts at ptr and wraps; fixed priority starts at 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (RR_EN) cand = IW'((int'(ptr) + i) % NUM_PORTS);
      else       cand = IW'(i);
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_next = BUSY;
        load       = 1'b1;
      end
      BUSY: if (pmem_resp) begin
        state_next = RESP;
        done       = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      grant        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      req_rdata    <= '0;
      req_resp     <= '0;
    end else begin
      req_resp <= '0;
      if (load) begin
        grant        <= win;
        pmem_address <= req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        pmem_wdata   <= req_wdata[int'(win)*LINE_WIDTH +: LINE_WIDTH];
        // a simultaneous read+write from one client is taken as a write
        pmem_write   <= req_write[win];
        pmem_read    <= ~req_write[win];
      end
      if (done) begin
        pmem_read       <= 1'b0;
        pmem_write      <= 1'b0;
        req_resp[grant] <= 1'b1;
        if (pmem_read) req_rdata <= pmem_rdata;
      end
      if (state == RESP && RR_EN) ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: three instances (2-port RR, 2-port fixed, 4-port RR) share stimulus;
// sel picks which one is observed and modelled.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [3:0]     rd, wr;
  logic [127:0]   addr;
  logic [1023:0]  wd;
  logic [255:0]   prdata;
  logic           presp;
  int             sel;

  logic [255:0] a_rdata, b_rdata, c_rdata, a_pwd, b_pwd, c_pwd, o_rdata, o_pwd;
  logic [1:0]   a_resp, b_resp;
  logic [3:0]   c_resp, o_resp;
  logic [31:0]  a_paddr, b_paddr, c_paddr, o_paddr;
  logic         a_prd, a_pwr, b_prd, b_pwr, c_prd, c_pwr, o_prd, o_pwr;

  pmem_arbiter #(.NUM_PORTS(2), .RR_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_read(rd[1:0]), .req_write(wr[1:0]),
    .req_address(addr[63:0]), .req_wdata(wd[511:0]), .req_rdata(a_rdata), .req_resp(a_resp),
    .pmem_read(a_prd), .pmem_write(a_pwr), .pmem_address(a_paddr), .pmem_wdata(a_pwd),
    .pmem_rdata(prdata), .pmem_resp(presp));

  pmem_arbiter #(.NUM_PORTS(2), .RR_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_read(rd[1:0]), .req_write(wr[1:0]),
    .req_address(addr[63:0]), .req_wdata(wd[511:0]), .req_rdata(b_rdata), .req_resp(b_resp),
    .pmem_read(b_prd), .pmem_write(b_pwr), .pmem_address(b_paddr), .pmem_wdata(b_pwd),
    .pmem_rdata(prdata), .pmem_resp(presp));

  pmem_arbiter #(.NUM_PORTS(4), .RR_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_read(rd), .req_write(wr),
    .req_address(addr), .req_wdata(wd), .req_rdata(c_rdata), .req_resp(c_resp),
    .pmem_read(c_prd), .pmem_write(c_pwr), .pmem_address(c_paddr), .pmem_wdata(c_pwd),
    .pmem_rdata(prdata), .pmem_resp(presp));

  always_comb begin
    case (sel)
      0: begin
        o_rdata = a_rdata; o_resp = {2'b00, a_resp}; o_prd = a_prd; o_pwr = a_pwr;
        o_paddr = a_paddr; o_pwd = a_pwd;
      end
      1: begin
        o_rdata = b_rdata; o_resp = {2'b00, b_resp}; o_prd = b_prd; o_pwr = b_pwr;
        o_paddr = b_paddr; o_pwd = b_pwd;
      end
      default: begin
        o_rdata = c_rdata; o_resp = c_resp; o_prd = c_prd; o_pwr = c_pwr;
        o_paddr = c_paddr; o_pwd = c_pwd;
      end
    endcase
  end

  int n_cmp = 0, n_err = 0;
  int illegal_seen = 0;

  // Read and write together from one client is illegal stimulus; flag it.
  always @(posedge clk) begin
    if (!rst && |(rd & wr)) begin
      illegal_seen <= illegal_seen + 1;
      $display("note: client asserted read and write together (rd=%b wr=%b)", rd, wr);
    end
  end

  // Reference model state
  int           mptr;
  logic [255:0] mrdata;
  int           age[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int np_of();
    return (sel == 2) ? 4 : 2;
  endfunction

  function automatic bit rr_of();
    return sel != 1;
  endfunction

  function automatic int pick(input logic [3:0] pend, input int np, input bit rr, input int ptr);
    for (int i = 0; i < np; i++) begin
      int idx;
      idx = rr ? (ptr + i) % np : i;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int dec(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; rd = '0; wr = '0; presp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = 0; mrdata = '0;
    for (int p = 0; p < 4; p++) age[p] = 0;
    chk("rst_pmem_read", 256'(o_prd), 256'(0));
    chk("rst_pmem_write", 256'(o_pwr), 256'(0));
    chk("rst_req_resp", 256'(o_resp), 256'(0));
    chk("rst_address", 256'(o_paddr), 256'(0));
    chk("rst_wdata", o_pwd, 256'(0));
    chk("rst_rdata", o_rdata, 256'(0));
  endtask

  // One arbitration + memory transaction, starting in IDLE with requests already driven.
  task automatic do_txn(input int k, input logic [255:0] line, output int got_port, output bit got_wr);
    int np, w;
    bit rr, ewr;
    logic [3:0]   pend;
    logic [31:0]  ea;
    logic [255:0] ew;
    np   = np_of();
    rr   = rr_of();
    pend = (rd | wr) & ((np == 4) ? 4'hf : 4'h3);
    w    = pick(pend, np, rr, mptr);
    got_port = -1; got_wr = 1'b0;
    if (w < 0) begin
      chk("txn_has_pending", 256'(0), 256'(1));
      return;
    end
    ea  = addr[w*32 +: 32];
    ew  = wd[w*256 +: 256];
    ewr = wr[w];
    if (rr) chk("starve_bound", 256'(age[w] <= np - 1), 256'(1));
    for (int p = 0; p < 4; p++) begin
      if (p == w) age[p] = 0;
      else if (pend[p]) age[p]++;
    end
    @(posedge clk); #1;
    got_wr = o_pwr;
    chk("grant_read", 256'(o_prd), 256'(!ewr));
    chk("grant_write", 256'(o_pwr), 256'(ewr));
    chk("grant_addr", 256'(o_paddr), 256'(ea));
    chk("grant_wdata", o_pwd, ew);
    for (int c = 0; c < k; c++) begin
      for (int p = 0; p < 4; p++) if (p != w) addr[p*32 +: 32] = $urandom;
      @(posedge clk); #1;
      chk("busy_hold", 256'({o_prd, o_pwr, o_paddr}), 256'({!ewr, ewr, ea}));
      chk("busy_no_resp", 256'(o_resp), 256'(0));
    end
    presp = 1'b1; prdata = line;
    @(posedge clk); #1;
    presp = 1'b0; prdata = {8{$urandom}};
    chk("resp_onehot", 256'(o_resp), 256'(4'b0001 << w));
    chk("resp_drop_req", 256'({o_prd, o_pwr}), 256'(0));
    if (!ewr) mrdata = line;
    chk("resp_rdata", o_rdata, mrdata);
    got_port = dec(o_resp);
    rd[w] = 1'b0; wr[w] = 1'b0;
    if (rr) mptr = (w + 1) % np;
    @(posedge clk); #1;
    chk("resp_pulse", 256'(o_resp), 256'(0));
  endtask

  typedef struct {
    int         sel;
    bit         do_rst;
    logic [3:0] rd;
    logic [3:0] wr;
    int         exp_port;
    bit         exp_wr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int gp;
    bit gw;
    rst = 1'b1; rd = '0; wr = '0; addr = '0; wd = '0; prdata = '0; presp = 1'b0; sel = 0;

    // 2-port RR: simultaneous pairs alternate
    tbl[0]  = '{0, 1'b1, 4'b0001, 4'b0010, 0, 1'b0};
    tbl[1]  = '{0, 1'b0, 4'b0001, 4'b0010, 1, 1'b1};
    tbl[2]  = '{0, 1'b0, 4'b0001, 4'b0010, 0, 1'b0};
    tbl[3]  = '{0, 1'b0, 4'b0000, 4'b0011, 1, 1'b1};
    // 2-port fixed priority: port0 keeps winning
    tbl[4]  = '{1, 1'b1, 4'b0011, 4'b0000, 0, 1'b0};
    tbl[5]  = '{1, 1'b0, 4'b0011, 4'b0000, 0, 1'b0};
    tbl[6]  = '{1, 1'b0, 4'b0001, 4'b0010, 0, 1'b0};
    tbl[7]  = '{1, 1'b0, 4'b0010, 4'b0000, 1, 1'b0};
    // 4-port RR: all request, order 0,1,2,3,0 then pointer-relative picks
    tbl[8]  = '{2, 1'b1, 4'b1111, 4'b0000, 0, 1'b0};
    tbl[9]  = '{2, 1'b0, 4'b1111, 4'b0000, 1, 1'b0};
    tbl[10] = '{2, 1'b0, 4'b1111, 4'b0000, 2, 1'b0};
    tbl[11] = '{2, 1'b0, 4'b1111, 4'b0000, 3, 1'b0};
    tbl[12] = '{2, 1'b0, 4'b1111, 4'b0000, 0, 1'b0};
    tbl[13] = '{2, 1'b0, 4'b0000, 4'b1000, 3, 1'b1};
    tbl[14] = '{2, 1'b0, 4'b0101, 4'b0000, 0, 1'b0};
    tbl[15] = '{2, 1'b0, 4'b0101, 4'b0000, 2, 1'b0};

    // Single read on port 1, adaptor latency 4
    sel = 0;
    do_reset();
    addr[63:32] = 32'h0000_1040;
    rd = 4'b0010;
    do_txn(4, {32{8'hA5}}, gp, gw);
    chk("t1_port", 256'(gp), 256'(1));
    chk("t1_rdata", o_rdata, {32{8'hA5}});

    foreach (tbl[i]) begin
      sel = tbl[i].sel;
      if (tbl[i].do_rst) do_reset();
      for (int p = 0; p < 4; p++) begin
        addr[p*32 +: 32]  = $urandom;
        wd[p*256 +: 256]  = {8{$urandom}};
      end
      rd = tbl[i].rd; wr = tbl[i].wr;
      do_txn($urandom_range(0, 3), {8{$urandom}}, gp, gw);
      chk($sformatf("tbl%0d_port", i), 256'(gp), 256'(tbl[i].exp_port));
      chk($sformatf("tbl%0d_op", i), 256'(gw), 256'(tbl[i].exp_wr));
    end

    // Reset mid-BUSY: pointer returns to 0, late pmem_resp ignored
    sel = 0;
    do_reset();
    rd = 4'b0001;
    do_txn(1, {8{$urandom}}, gp, gw);
    rd = 4'b0010;
    @(posedge clk); #1;
    chk("t5_busy", 256'(o_prd), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd = '0; mptr = 0; mrdata = '0;
    chk("t5_read_cleared", 256'(o_prd), 256'(0));
    chk("t5_resp_cleared", 256'(o_resp), 256'(0));
    chk("t5_addr_cleared", 256'(o_paddr), 256'(0));
    presp = 1'b1; prdata = {32{8'h3C}};
    @(posedge clk); #1;
    presp = 1'b0;
    chk("t5_late_resp", 256'({o_resp, o_prd, o_pwr}), 256'(0));
    chk("t5_late_rdata", o_rdata, 256'(0));
    @(posedge clk); #1;
    chk("t5_idle_resp", 256'(o_resp), 256'(0));
    rd = 4'b0011;
    do_txn(2, {8{$urandom}}, gp, gw);
    chk("t5_ptr_reset", 256'(gp), 256'(0));

    // Illegal read+write on one port: write wins and the monitor flags it
    do_reset();
    addr[31:0] = 32'h0000_0300;
    rd = 4'b0001; wr = 4'b0001;
    do_txn(2, {8{$urandom}}, gp, gw);
    chk("t6_write_wins", 256'(gw), 256'(1));
    chk("t6_flagged", 256'(illegal_seen > 0), 256'(1));

    // Randomised traffic against the model on every instance
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int t = 0; t < 60; t++) begin
        int np;
        np = np_of();
        for (int p = 0; p < np; p++) begin
          if (!(rd[p] | wr[p])) begin
            if ($urandom_range(0, 2) != 0) begin
              if ($urandom_range(0, 1) == 1) wr[p] = 1'b1;
              else                           rd[p] = 1'b1;
              addr[p*32 +: 32] = $urandom;
              wd[p*256 +: 256] = {8{$urandom}};
              age[p] = 0;
            end
          end else if ($urandom_range(0, 9) == 0) begin
            rd[p] = 1'b0; wr[p] = 1'b0; age[p] = 0;
          end
        end
        if (((rd | wr) & ((np == 4) ? 4'hf : 4'h3)) == 4'b0) begin
          int p;
          p = $urandom_range(0, np - 1);
          rd[p] = 1'b1; age[p] = 0;
        end
        do_txn($urandom_range(0, 5), {8{$urandom}}, gp, gw);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
